pipe_ctrl: RTL and testbench

- Sequences the five-stage pipeline (IF/ID/EX/MEM/WB) from the hazard logic's `doStall`/`doFwd` decision, EX-stage branch resolution, the multi-cycle data-memory handshake and HLT/resume.
- Drives the per-stage register enables and bubble (flush) controls.
- Keeps saturating stall/flush performance counters.
- Includes a memory-wait watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_ctrl_sat_counter.sv | 20 ++
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encoding and default sizes shared by the pipeline
// controller and its performance counters.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2,
    HALT    = 2'd3
  } pipeState_e;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_MEM_TO = 255;
  localparam int DEF_TO_W   = 8;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones.
// Ports: clk, rst (async, active-high), inc (count this cycle),
//        clr (synchronous clear, wins over inc), cnt (current value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequences the IF/ID/EX/MEM/WB pipeline from hazard, branch,
// data-memory and halt/resume events.
// Inputs : doStall, doFwd, brTaken, memReq, memAck, halt, resume, cntClr.
// Outputs: per-stage enables enIF/enID/enEX/enMEM, bubble controls
//          flushID/flushEX, halted, sticky memErr, and saturating
//          stallCnt/flushCnt/fwdCnt performance counters.
// All pipeline controls are combinational from state and inputs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int MEM_TO = DEF_MEM_TO,
  parameter int TO_W   = DEF_TO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             doStall,
  input  logic             doFwd,
  input  logic             brTaken,
  input  logic             memReq,
  input  logic             memAck,
  input  logic             halt,
  input  logic             resume,
  input  logic             cntClr,
  output logic             enIF,
  output logic             enID,
  output logic             enEX,
  output logic             enMEM,
  output logic             flushID,
  output logic             flushEX,
  output logic             halted,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt,
  output logic [CNT_W-1:0] fwdCnt
);

  pipeState_e state, nextState;
  logic [TO_W-1:0] wdCnt;
  logic memWait, wdHit;
  logic stallInc, flushInc, fwdInc;

  // A miss in MEM freezes everything; a same-cycle ack is a normal access.
  assign memWait = memReq & ~memAck;
  assign wdHit   = (wdCnt == TO_W'(MEM_TO));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      BOOT:    nextState = RUN;
      RUN: begin
        if (halt)         nextState = HALT;
        else if (memWait) nextState = MEMWAIT;
      end
      MEMWAIT: begin
        if (memAck)     nextState = RUN;
        else if (wdHit) nextState = HALT;
      end
      HALT:    if (resume && !memErr) nextState = RUN;
      default: nextState = BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    enIF = 1'b0; enID = 1'b0; enEX = 1'b0; enMEM = 1'b0;
    flushID = 1'b0; flushEX = 1'b0; halted = 1'b0;
    stallInc = 1'b0; flushInc = 1'b0; fwdInc = 1'b0;
    case (state)
      BOOT: begin
        flushID = 1'b1;
        flushEX = 1'b1;
      end
      RUN: begin
        if (halt) begin
          // everything frozen, nothing counted
        end else if (memWait) begin
          // branch/stall decisions stay in the frozen stages for later
          stallInc = 1'b1;
        end else if (brTaken) begin
          // the branch squashes whatever the stall would have held
          {enIF, enID, enEX, enMEM} = 4'hF;
          flushID  = 1'b1;
          flushEX  = 1'b1;
          flushInc = 1'b1;
          fwdInc   = doFwd;
        end else if (doStall) begin
          enEX     = 1'b1;
          enMEM    = 1'b1;
          flushEX  = 1'b1;
          stallInc = 1'b1;
        end else begin
          {enIF, enID, enEX, enMEM} = 4'hF;
          fwdInc = doFwd;
        end
      end
      MEMWAIT: stallInc = 1'b1;
      HALT:    halted   = 1'b1;
      default: ;
    endcase
  end

  // Memory-wait watchdog: 1 on entry, counts MEMWAIT cycles, trips at MEM_TO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdCnt  <= '0;
      memErr <= 1'b0;
    end else begin
      case (state)
        RUN:     if (!halt && memWait) wdCnt <= TO_W'(1);
        MEMWAIT: begin
          if (memAck) begin
            wdCnt <= '0;
          end else if (wdHit) begin
            wdCnt  <= '0;
            memErr <= 1'b1;
          end else begin
            wdCnt <= wdCnt + TO_W'(1);
          end
        end
        default: wdCnt <= '0;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk(clk), .rst(rst), .inc(stallInc), .clr(cntClr), .cnt(stallCnt));
  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk(clk), .rst(rst), .inc(flushInc), .clr(cntClr), .cnt(flushCnt));
  sat_counter #(.W(CNT_W)) uFwdCnt (
    .clk(clk), .rst(rst), .inc(fwdInc), .clr(cntClr), .cnt(fwdCnt));

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic doStall = 0, doFwd = 0, brTaken = 0, memReq = 0, memAck = 0;
  logic halt = 0, resume = 0, cntClr = 0;

  logic enIF, enID, enEX, enMEM, flushID, flushEX, halted, memErr;
  logic [15:0] stallCnt, flushCnt, fwdCnt;
  logic sEnIF, sEnID, sEnEX, sEnMEM, sFlushID, sFlushEX, sHalted, sMemErr;
  logic [1:0] sStallCnt, sFlushCnt, sFwdCnt;

  typedef struct packed {
    logic [3:0] en;
    logic [1:0] fl;
    logic       hlt;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int nChk = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(16), .MEM_TO(5), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .doStall(doStall), .doFwd(doFwd), .brTaken(brTaken),
    .memReq(memReq), .memAck(memAck), .halt(halt), .resume(resume),
    .cntClr(cntClr), .enIF(enIF), .enID(enID), .enEX(enEX), .enMEM(enMEM),
    .flushID(flushID), .flushEX(flushEX), .halted(halted), .memErr(memErr),
    .stallCnt(stallCnt), .flushCnt(flushCnt), .fwdCnt(fwdCnt));

  // narrow-counter copy sharing the same stimulus, for saturation
  pipe_ctrl #(.CNT_W(2)) dutS (
    .clk(clk), .rst(rst), .doStall(doStall), .doFwd(doFwd), .brTaken(brTaken),
    .memReq(memReq), .memAck(memAck), .halt(halt), .resume(resume),
    .cntClr(cntClr), .enIF(sEnIF), .enID(sEnID), .enEX(sEnEX), .enMEM(sEnMEM),
    .flushID(sFlushID), .flushEX(sFlushEX), .halted(sHalted), .memErr(sMemErr),
    .stallCnt(sStallCnt), .flushCnt(sFlushCnt), .fwdCnt(sFwdCnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChk++;
    if (obs !== expv) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Scoreboard consumer: compares the combinational controls mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("en",     32'({enIF, enID, enEX, enMEM}), 32'(e.en));
      chk("flush",  32'({flushID, flushEX}),        32'(e.fl));
      chk("halted", 32'(halted),                    32'(e.hlt));
      chk("memErr", 32'(memErr),                    32'(e.err));
    end
  end

  task automatic idle();
    doStall = 0; doFwd = 0; brTaken = 0; memReq = 0; memAck = 0;
    halt = 0; resume = 0; cntClr = 0;
  endtask

  // Called at posedge+1 with inputs already set; runs one cycle.
  task automatic step(input logic [3:0] en, input logic [1:0] fl,
                      input logic h, input logic e);
    exp_t x;
    x.en = en; x.fl = fl; x.hlt = h; x.err = e;
    sb.push_back(x);
    @(negedge clk);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic cnts(input string tag, input int st, input int fl, input int fw);
    chk({tag, ".stall"}, 32'(stallCnt), 32'(st));
    chk({tag, ".flush"}, 32'(flushCnt), 32'(fl));
    chk({tag, ".fwd"},   32'(fwdCnt),   32'(fw));
  endtask

  initial begin
    // reset held: BOOT outputs, cleared counters
    repeat (2) @(posedge clk);
    #1;
    chk("rst.en", 32'({enIF, enID, enEX, enMEM}), 32'h0);
    chk("rst.flush", 32'({flushID, flushEX}), 32'h3);
    cnts("rst", 0, 0, 0);
    rst = 1'b0;

    step(4'h0, 2'b11, 0, 0);                 // BOOT
    step(4'hF, 2'b00, 0, 0);                 // RUN idle

    // load-use stall for two cycles
    doStall = 1; step(4'b0011, 2'b01, 0, 0);
    doStall = 1; step(4'b0011, 2'b01, 0, 0);
    cnts("stall2", 2, 0, 0);
    // branch beats stall
    doStall = 1; brTaken = 1; step(4'hF, 2'b11, 0, 0);
    cnts("branch", 2, 1, 0);
    // forwarding counted only when advancing
    doFwd = 1; step(4'hF, 2'b00, 0, 0);
    doFwd = 1; doStall = 1; step(4'b0011, 2'b01, 0, 0);
    cnts("fwd", 3, 1, 1);
    chk("sat.pre", 32'(sStallCnt), 32'd3);
    cntClr = 1; step(4'hF, 2'b00, 0, 0);
    cnts("clr", 0, 0, 0);

    // memory miss: ack on the 4th cycle
    for (int i = 0; i < 4; i++) begin
      memReq = 1; memAck = (i == 3); doStall = (i == 1); brTaken = (i == 2);
      step(4'h0, 2'b00, 0, 0);
    end
    cnts("mem", 4, 0, 0);
    chk("mem.sat", 32'(sStallCnt), 32'd3);
    step(4'hF, 2'b00, 0, 0);                 // back in RUN
    memReq = 1; memAck = 1; step(4'hF, 2'b00, 0, 0);
    step(4'hF, 2'b00, 0, 0);
    cnts("mem1", 4, 0, 0);

    // halt / resume
    halt = 1; step(4'h0, 2'b00, 0, 0);
    step(4'h0, 2'b00, 1, 0);
    doStall = 1; step(4'h0, 2'b00, 1, 0);
    resume = 1; step(4'h0, 2'b00, 1, 0);
    step(4'hF, 2'b00, 0, 0);
    cnts("halt", 4, 0, 0);

    // saturation on the narrow copy, clear beating a concurrent stall
    cntClr = 1; step(4'hF, 2'b00, 0, 0);
    repeat (6) begin
      doStall = 1; step(4'b0011, 2'b01, 0, 0);
    end
    chk("sat6.wide", 32'(stallCnt), 32'd6);
    chk("sat6.narrow", 32'(sStallCnt), 32'd3);
    doStall = 1; cntClr = 1; step(4'b0011, 2'b01, 0, 0);
    chk("clrstall.wide", 32'(stallCnt), 32'd0);
    chk("clrstall.narrow", 32'(sStallCnt), 32'd0);

    // watchdog timeout after 5 MEMWAIT cycles
    memReq = 1; step(4'h0, 2'b00, 0, 0);     // entry
    repeat (5) begin
      memReq = 1; step(4'h0, 2'b00, 0, 0);
    end
    memReq = 1; step(4'h0, 2'b00, 1, 1);     // HALT with error
    resume = 1; step(4'h0, 2'b00, 1, 1);     // resume ignored
    step(4'h0, 2'b00, 1, 1);
    chk("to.stall", 32'(stallCnt), 32'd6);

    // asynchronous reset mid-cycle
    rst = 1'b1;
    #1;
    chk("arst.en", 32'({enIF, enID, enEX, enMEM}), 32'h0);
    chk("arst.flush", 32'({flushID, flushEX}), 32'h3);
    chk("arst.halted", 32'(halted), 32'd0);
    chk("arst.memErr", 32'(memErr), 32'd0);
    chk("arst.stall", 32'(stallCnt), 32'd0);
    #1;
    rst = 1'b0;
    step(4'h0, 2'b11, 0, 0);                 // BOOT
    step(4'hF, 2'b00, 0, 0);                 // RUN

    if (sb.size() != 0) begin
      nChk++;
      nFail++;
      $display("FAIL sb.drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
